// File: rtl/nonce_range_generator.sv
// Nonce range walker: issues [start_nonce, end_nonce] round-robin to NUM_CORES hash cores.
// Optional NONCE_GEN_EXTRANONCE_EN: wrap the range forever and count passes on extranonce.
module nonce_range_generator #(
    parameter int WIDTH     = 32,
    parameter int NUM_CORES = 4,
    parameter int CORE_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  start_nonce,
    input  logic [WIDTH-1:0]  end_nonce,
    input  logic              enable,
    input  logic              stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_nonce,
    output logic [CORE_W-1:0] out_core,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              range_err,
`ifdef NONCE_GEN_EXTRANONCE_EN
    output logic [31:0]       extranonce,
`endif
    output logic [WIDTH:0]    issued
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH-1:0]  lim;
    logic              handshake;
    logic              at_end;
    logic              bad_range;

    assign handshake = out_valid & out_ready;
    assign at_end    = (cur == lim);
    assign bad_range = (start_nonce > end_nonce);
    assign out_nonce = cur;

`ifdef NONCE_GEN_EXTRANONCE_EN
    logic [WIDTH-1:0] first;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = bad_range ? DONE : RUN;
        end else if (state == RUN) begin
            if (stop) begin
                state_next = DONE;
            end
`ifndef NONCE_GEN_EXTRANONCE_EN
            else if (handshake && at_end) begin
                state_next = DONE;
            end
`endif
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        if (state == RUN) begin
            out_valid = enable & ~stop;
            busy      = 1'b1;
        end
    end

    // Datapath; load wins over stop and over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            lim       <= '0;
            out_core  <= '0;
            issued    <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            range_err <= 1'b0;
`ifdef NONCE_GEN_EXTRANONCE_EN
            first      <= '0;
            extranonce <= '0;
`endif
        end else if (load) begin
            cur       <= start_nonce;
            lim       <= end_nonce;
            out_core  <= '0;
            issued    <= '0;
            aborted   <= 1'b0;
            done      <= bad_range;
            range_err <= bad_range;
`ifdef NONCE_GEN_EXTRANONCE_EN
            first      <= start_nonce;
            extranonce <= '0;
`endif
        end else if (state == RUN) begin
            if (stop) begin
                done    <= 1'b1;
                aborted <= 1'b1;
            end else if (handshake) begin
                out_core <= (out_core == CORE_W'(NUM_CORES - 1)) ? '0 : out_core + 1'b1;
`ifdef NONCE_GEN_EXTRANONCE_EN
                if (issued != '1) issued <= issued + 1'b1;
                if (at_end) begin
                    cur        <= first;
                    extranonce <= extranonce + 32'd1;
                end else begin
                    cur <= cur + 1'b1;
                end
`else
                issued <= issued + 1'b1;
                // Never increment past lim, so an all-ones end cannot wrap cur to 0.
                if (at_end) done <= 1'b1;
                else        cur  <= cur + 1'b1;
`endif
            end
        end
    end

endmodule
